// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_XOR   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   // Registered (Moore) part of the control word for one state.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       reg_write;
      logic       pc_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] result_src;
      logic [2:0] imm_src;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   // Control word a state presents for its whole duration.
   function automatic ctrl_t state_ctrl(state_t s, logic is_sw, logic [2:0] alu_op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req  = 1'b1;
            c.src_a    = SRCA_PC;
            c.src_b    = SRCB_FOUR;
            c.alu_ctrl = ALU_ADD;
         end
         S_DECODE: begin
            c.src_a   = SRCA_OLDPC;
            c.src_b   = SRCB_IMM;
            c.imm_src = IMM_B;
         end
         S_MEMADR: begin
            c.src_a   = SRCA_RS1;
            c.src_b   = SRCB_IMM;
            c.imm_src = is_sw ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_MEM;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.adr_src = 1'b1;
         end
         S_EXECR: begin
            c.src_a    = SRCA_RS1;
            c.src_b    = SRCB_RS2;
            c.alu_ctrl = alu_op;
         end
         S_EXECI: begin
            c.src_a    = SRCA_RS1;
            c.src_b    = SRCB_IMM;
            c.imm_src  = IMM_I;
            c.alu_ctrl = alu_op;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            c.src_a    = SRCA_RS1;
            c.src_b    = SRCB_RS2;
            c.alu_ctrl = ALU_SUB;
         end
         S_JAL: begin
            c.src_a      = SRCA_OLDPC;
            c.src_b      = SRCB_FOUR;
            c.result_src = RES_ALU;
            c.pc_write   = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_LUI: begin
            c.src_b      = SRCB_IMM;
            c.imm_src    = IMM_U;
            c.alu_ctrl   = ALU_PASSB;
            c.result_src = RES_ALU;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Unified instruction/data memory handshake.
interface mc_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic adr_src;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output adr_src, input mem_ready);
   modport slave  (input mem_req, input mem_we, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// funct3/funct7b5 to ALU operation for register and immediate arithmetic.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_r,
   output logic [2:0] alu_ctrl,
   output logic       invalid
);

   // Only add/sub, xor and and exist in this core; everything else is invalid.
   always_comb begin
      alu_ctrl = ALU_ADD;
      invalid  = 1'b0;
      case (funct3)
         3'b000:  alu_ctrl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b100:  alu_ctrl = ALU_XOR;
         3'b111:  alu_ctrl = ALU_AND;
         default: invalid  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: one instruction at a time over a shared
// ALU and a single memory port that may insert wait states.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   mc_control_fsm_if.master   mem,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         result_src,
   output logic [2:0]         imm_src,
   output logic [2:0]         alu_ctrl,
   output logic               illegal,
   output logic               bus_err
);

   localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(MEM_TIMEOUT);

   state_t           state, state_d;
   ctrl_t            ctrl_q;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             to_hit;
   logic             set_ill, set_berr;
   logic [2:0]       dec_alu;
   logic             dec_bad;
   logic             br_take, br_bad;

   mc_alu_decoder u_alu_dec (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_r     (op == OP_R),
      .alu_ctrl (dec_alu),
      .invalid  (dec_bad)
   );

   assign cnt_inc = {1'b0, wait_cnt} + (CNT_W+1)'(1);
   // The cycle that would make the wait count equal MEM_TIMEOUT aborts instead.
   assign to_hit  = (MEM_TIMEOUT != 0) && (cnt_inc == TO_LIM);
   assign br_take = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? !zero : 1'b0;
   assign br_bad  = (funct3 != 3'b000) && (funct3 != 3'b001);

   // Next-state decision; mem_ready takes priority over a coincident timeout.
   always_comb begin
      state_d  = state;
      set_ill  = 1'b0;
      set_berr = 1'b0;
      case (state)
         S_FETCH, S_MEMREAD, S_MEMWRITE: begin
            if (mem.mem_ready)
               state_d = (state == S_FETCH)   ? S_DECODE :
                         (state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
            else if (to_hit) begin
               state_d  = S_HALT;
               set_berr = 1'b1;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = S_LUI;
               default: begin
                  state_d = S_HALT;
                  set_ill = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_EXECR, S_EXECI: begin
            if (dec_bad) begin
               state_d = S_HALT;
               set_ill = 1'b1;
            end else
               state_d = S_ALUWB;
         end
         S_BRANCH: begin
            if (br_bad) begin
               state_d = S_HALT;
               set_ill = 1'b1;
            end else
               state_d = S_FETCH;
         end
         S_MEMWB, S_ALUWB, S_JAL, S_LUI: state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   // State, registered control word for the upcoming state, wait counter, sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         ctrl_q   <= state_ctrl(S_FETCH, 1'b0, ALU_ADD);
         wait_cnt <= '0;
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         state   <= state_d;
         ctrl_q  <= state_ctrl(state_d, op == OP_SW, dec_alu);
         illegal <= illegal | set_ill;
         bus_err <= bus_err | set_berr;
         if (state_d != state)
            wait_cnt <= '0;
         else if (ctrl_q.mem_req && !mem.mem_ready)
            wait_cnt <= cnt_inc[CNT_W-1:0];
      end
   end

   // The request is gated by reset so an in-flight wait is abandoned at once.
   assign mem.mem_req = ctrl_q.mem_req & rst_n;
   assign mem.mem_we  = ctrl_q.mem_we;
   assign mem.adr_src = ctrl_q.adr_src;

   // Fetch completion and branch outcome are only known within the cycle itself.
   assign ir_write   = (state == S_FETCH) && mem.mem_ready;
   assign pc_write   = ctrl_q.pc_write | ir_write | ((state == S_BRANCH) && br_take);
   assign reg_write  = ctrl_q.reg_write;
   assign alu_src_a  = ctrl_q.src_a;
   assign alu_src_b  = ctrl_q.src_b;
   assign result_src = ctrl_q.result_src;
   assign alu_ctrl   = ctrl_q.alu_ctrl;
   // jal needs the J immediate for the target computed during DECODE.
   assign imm_src    = ((state == S_DECODE) && (op == OP_JAL)) ? IMM_J : ctrl_q.imm_src;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle control-word vectors plus error sequences.
module tb_mc_control_fsm;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
      logic [1:0] a, b, rs;
      logic [2:0] imm, alu;
   } outv_t;

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        z;
      logic [9:0]  rdy;
      int          n;
      outv_t [9:0] exp;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7b5 = 1'b0, zero = 1'b0;
   logic       ir_write, pc_write, reg_write, illegal, bus_err;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] imm_src, alu_ctrl;

   mc_control_fsm_if mem_if();

   mc_control_fsm #(.MEM_TIMEOUT(5), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem(mem_if), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
      .illegal(illegal), .bus_err(bus_err));

   always #5 clk = ~clk;

   int    n_cmp = 0, n_bad = 0;
   outv_t sb[$];
   vec_t  vecs[$];

   outv_t E_FW, E_FR, E_DEC, E_DECJ, E_AWB, E_MA_LW, E_MA_SW, E_MR, E_MWB, E_MW, E_JAL, E_LUI, E_HALT;

   function automatic outv_t mk(logic req, logic we, logic adr, logic ir, logic pc, logic rw,
                                logic [1:0] a, logic [1:0] b, logic [1:0] rs,
                                logic [2:0] imm, logic [2:0] alu);
      return {req, we, adr, ir, pc, rw, a, b, rs, imm, alu};
   endfunction

   function automatic outv_t xr(logic [2:0] alu); return mk(0,0,0,0,0,0, 2,0,0, 0,alu); endfunction
   function automatic outv_t xi(logic [2:0] alu); return mk(0,0,0,0,0,0, 2,1,0, 0,alu); endfunction
   function automatic outv_t br(logic pc);        return mk(0,0,0,0,pc,0, 2,0,0, 0,3'b001); endfunction

   function automatic outv_t got_v();
      return {mem_if.mem_req, mem_if.mem_we, mem_if.adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl};
   endfunction

   task automatic add(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                      logic [9:0] rdy, int n,
                      outv_t e0, outv_t e1 = '0, outv_t e2 = '0, outv_t e3 = '0, outv_t e4 = '0,
                      outv_t e5 = '0, outv_t e6 = '0, outv_t e7 = '0, outv_t e8 = '0, outv_t e9 = '0);
      vec_t v;
      v.name = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.n = n;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
      v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7; v.exp[8] = e8; v.exp[9] = e9;
      vecs.push_back(v);
   endtask

   task automatic check_bit(string nm, logic got, logic want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   // One clock cycle: drive mem_ready, queue the expected word, compare mid-cycle.
   // Entered and left at posedge+1.
   task automatic cycle(string nm, int idx, logic rdy, outv_t e);
      outv_t w, g;
      mem_if.mem_ready = rdy;
      sb.push_back(e);
      @(negedge clk);
      w = sb.pop_front();
      g = got_v();
      n_cmp++;
      if (g !== w) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, g, w);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_if.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      E_FW    = mk(1,0,0,0,0,0, 0,2,0, 0,0);
      E_FR    = mk(1,0,0,1,1,0, 0,2,0, 0,0);
      E_DEC   = mk(0,0,0,0,0,0, 1,1,0, 2,0);
      E_DECJ  = mk(0,0,0,0,0,0, 1,1,0, 3,0);
      E_AWB   = mk(0,0,0,0,0,1, 0,0,0, 0,0);
      E_MA_LW = mk(0,0,0,0,0,0, 2,1,0, 0,0);
      E_MA_SW = mk(0,0,0,0,0,0, 2,1,0, 1,0);
      E_MR    = mk(1,0,1,0,0,0, 0,0,0, 0,0);
      E_MWB   = mk(0,0,0,0,0,1, 0,0,1, 0,0);
      E_MW    = mk(1,1,1,0,0,0, 0,0,0, 0,0);
      E_JAL   = mk(0,0,0,0,1,1, 1,2,2, 0,0);
      E_LUI   = mk(0,0,0,0,0,1, 0,1,2, 4,4);
      E_HALT  = '0;

      add("add",      OP_R,  3'b000, 0, 0, 10'b0000000001, 4, E_FR, E_DEC, xr(3'b000), E_AWB);
      add("add_fw2",  OP_R,  3'b000, 0, 0, 10'b0000000100, 6, E_FW, E_FW, E_FR, E_DEC, xr(3'b000), E_AWB);
      add("sub",      OP_R,  3'b000, 1, 0, 10'b0000000001, 4, E_FR, E_DEC, xr(3'b001), E_AWB);
      add("xor",      OP_R,  3'b100, 0, 0, 10'b0000000001, 4, E_FR, E_DEC, xr(3'b010), E_AWB);
      add("andi",     OP_I,  3'b111, 0, 0, 10'b0000000001, 4, E_FR, E_DEC, xi(3'b011), E_AWB);
      add("addi_f7",  OP_I,  3'b000, 1, 0, 10'b0000000001, 4, E_FR, E_DEC, xi(3'b000), E_AWB);
      add("lw_w3",    OP_LW, 3'b010, 0, 0, 10'b0001000001, 8, E_FR, E_DEC, E_MA_LW, E_MR, E_MR, E_MR, E_MR, E_MWB);
      add("lw_w4",    OP_LW, 3'b010, 0, 0, 10'b0010000001, 9, E_FR, E_DEC, E_MA_LW, E_MR, E_MR, E_MR, E_MR, E_MR, E_MWB);
      add("sw",       OP_SW, 3'b010, 0, 0, 10'b0000001001, 4, E_FR, E_DEC, E_MA_SW, E_MW);
      add("sw_w1",    OP_SW, 3'b010, 0, 0, 10'b0000010001, 5, E_FR, E_DEC, E_MA_SW, E_MW, E_MW);
      add("beq_z1",   OP_BR, 3'b000, 0, 1, 10'b0000000001, 3, E_FR, E_DEC, br(1));
      add("beq_z0",   OP_BR, 3'b000, 0, 0, 10'b0000000001, 3, E_FR, E_DEC, br(0));
      add("bne_z1",   OP_BR, 3'b001, 0, 1, 10'b0000000001, 3, E_FR, E_DEC, br(0));
      add("bne_z0",   OP_BR, 3'b001, 0, 0, 10'b0000000001, 3, E_FR, E_DEC, br(1));
      add("jal",      OP_JAL,3'b000, 0, 0, 10'b0000000001, 3, E_FR, E_DECJ, E_JAL);
      add("lui",      OP_LUI,3'b000, 0, 0, 10'b0000000001, 3, E_FR, E_DEC, E_LUI);

      // Reset: asynchronous drop of mem_req while waiting in FETCH.
      set_instr(OP_R, 3'b000, 0, 0);
      #1;
      check_bit("rst_hold_req", mem_if.mem_req, 1'b0);
      do_reset();
      check_bit("rst_illegal", illegal, 1'b0);
      check_bit("rst_bus_err", bus_err, 1'b0);
      cycle("rst_fetch", 0, 1'b0, E_FW);
      cycle("rst_fetch", 1, 1'b0, E_FW);
      #2 rst_n = 1'b0;
      #1 check_bit("rst_async_req", mem_if.mem_req, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      cycle("rst_after", 0, 1'b0, E_FW);

      do_reset();
      foreach (vecs[k]) begin
         set_instr(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].z);
         for (int i = 0; i < vecs[k].n; i++)
            cycle(vecs[k].name, i, vecs[k].rdy[i], vecs[k].exp[i]);
         check_bit({vecs[k].name, "_illegal"}, illegal, 1'b0);
         check_bit({vecs[k].name, "_bus_err"}, bus_err, 1'b0);
      end

      // Unsupported opcode: HALT forever, nothing enabled.
      do_reset();
      set_instr(7'b1110011, 3'b000, 0, 0);
      cycle("ill_op", 0, 1'b1, E_FR);
      cycle("ill_op", 1, 1'b0, E_DEC);
      for (int i = 0; i < 20; i++) cycle("ill_op_halt", i, 1'($urandom_range(0, 1)), E_HALT);
      check_bit("ill_op_flag", illegal, 1'b1);
      check_bit("ill_op_berr", bus_err, 1'b0);

      // Unsupported funct3 on R-type: no write-back, then HALT.
      do_reset();
      set_instr(OP_R, 3'b010, 0, 0);
      cycle("ill_f3", 0, 1'b1, E_FR);
      cycle("ill_f3", 1, 1'b0, E_DEC);
      mem_if.mem_ready = 1'b0;
      @(negedge clk);
      check_bit("ill_f3_exec_rw", reg_write, 1'b0);
      check_bit("ill_f3_exec_pc", pc_write, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) cycle("ill_f3_halt", i, 1'($urandom_range(0, 1)), E_HALT);
      check_bit("ill_f3_flag", illegal, 1'b1);

      // Unsupported branch funct3: no PC write, then HALT.
      do_reset();
      set_instr(OP_BR, 3'b010, 0, 1);
      cycle("ill_br", 0, 1'b1, E_FR);
      cycle("ill_br", 1, 1'b0, E_DEC);
      cycle("ill_br", 2, 1'b0, br(0));
      for (int i = 0; i < 3; i++) cycle("ill_br_halt", i, 1'b0, E_HALT);
      check_bit("ill_br_flag", illegal, 1'b1);

      // Fetch timeout after 5 wait cycles; reset clears the flag.
      do_reset();
      set_instr(OP_R, 3'b000, 0, 0);
      for (int i = 0; i < 5; i++) cycle("to_fetch", i, 1'b0, E_FW);
      check_bit("to_fetch_berr", bus_err, 1'b1);
      check_bit("to_fetch_ill", illegal, 1'b0);
      for (int i = 0; i < 3; i++) cycle("to_fetch_halt", i, 1'($urandom_range(0, 1)), E_HALT);
      do_reset();
      check_bit("to_clear_berr", bus_err, 1'b0);
      cycle("to_clear", 0, 1'b0, E_FW);

      // Read timeout: MEMREAD gives up, no register write.
      do_reset();
      set_instr(OP_LW, 3'b010, 0, 0);
      cycle("to_rd", 0, 1'b1, E_FR);
      cycle("to_rd", 1, 1'b0, E_DEC);
      cycle("to_rd", 2, 1'b0, E_MA_LW);
      for (int i = 0; i < 5; i++) cycle("to_rd_wait", i, 1'b0, E_MR);
      check_bit("to_rd_berr", bus_err, 1'b1);
      cycle("to_rd_halt", 0, 1'b1, E_HALT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
